pulse_rate_meter: RTL and testbench

Measures the rate of a single-cycle pulse stream by counting the cycles in which the pulse input is high over a programmable window of clk cycles. It is the receive-side counterpart of the fractional counter: a pulse stream produced with addend A and maximum M, measured over a window of M cycles, returns approximately A. Results go downstream on a valid/ready handshake. Windows run back-to-back while enabled.

---
 rtl/counter_pkg.sv | 16 +
 rtl/sync_ff.sv | 28 ++
 rtl/pulse_rate_meter.sv | 120 ++++++++++++
 tb/tb_pulse_rate_meter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types for the pulse rate meter.
// Holds the FSM state encoding and the synchronizer depth check.
package counter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int SYNC_MAX = 4;

    function automatic bit sync_ok(int s);
        return (s >= 0) && (s <= SYNC_MAX);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer, asynchronously reset to zero.
// Output is the input delayed by STAGES clk cycles.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr_q;

    // shift chain, first flop captures the raw input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q = sr_q[STAGES-1];

endmodule

// File: rtl/pulse_rate_meter.sv
// Counts pulse-high cycles over a programmable window of clk cycles.
// Windows run back-to-back; results leave on a valid/ready handshake.
module pulse_rate_meter
    import counter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SYNC  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             pls,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] add,
    output logic             vld,
    input  logic             rdy,
    output logic             ovr
);

    logic             ps;
    logic             start;
    logic             last;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] win_q, win_d;
    logic [WIDTH-1:0] cyc_q, cyc_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] add_q, add_d;
    logic             vld_q, vld_d;
    logic             ovr_q, ovr_d;

    if (SYNC == 0) begin : g_direct
        assign ps = pls;
    end else if (sync_ok(SYNC)) begin : g_sync
        sync_ff #(
            .STAGES(SYNC)
        ) u_sync (
            .clk(clk),
            .rst(rst),
            .d  (pls),
            .q  (ps)
        );
    end else begin : g_bad
        $fatal(1, "pulse_rate_meter: SYNC must be 0..4");
    end

    assign start = ena && (max != '0);
    assign last  = (state_q == COUNT) && ena &&
                   (cyc_q == win_q - WIDTH'(1));

    // window sequencing and result/handshake next-state
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cyc_d   = cyc_q;
        acc_d   = acc_q;
        add_d   = add_q;
        vld_d   = vld_q;
        ovr_d   = ovr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COUNT;
                    win_d   = max;
                    cyc_d   = '0;
                    acc_d   = '0;
                end
            end
            COUNT: begin
                if (!ena) begin
                    state_d = IDLE;
                end else if (last) begin
                    if (start) begin
                        win_d = max;
                        cyc_d = '0;
                        acc_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    acc_d = acc_q + WIDTH'(ps);
                    cyc_d = cyc_q + WIDTH'(1);
                end
            end
        endcase
        if (last) begin
            add_d = acc_q + WIDTH'(ps);
            vld_d = 1'b1;
            ovr_d = vld_q & ~rdy;
        end else if (vld_q && rdy) begin
            vld_d = 1'b0;
            ovr_d = 1'b0;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            cyc_q   <= '0;
            acc_q   <= '0;
            add_q   <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cyc_q   <= cyc_d;
            acc_q   <= acc_d;
            add_q   <= add_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
        end
    end

    assign add = add_q;
    assign vld = vld_q;
    assign ovr = ovr_q;

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Directed bench for pulse_rate_meter: vector table plus corner sequences.
// Two instances cover SYNC=0 and SYNC=2 with shared stimulus.
module tb_pulse_rate_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        pls = 1'b0;
    logic        rdy = 1'b0;
    logic [31:0] max = '0;

    logic [31:0] add0, add2;
    logic        vld0, vld2;
    logic        ovr0, ovr2;

    int n_chk = 0;
    int n_err = 0;
    int tgen  = 0;
    int facc  = 0;

    typedef struct {
        logic        rst;
        logic        ena;
        logic        pls;
        logic        rdy;
        logic [31:0] max;
        logic        vld;
        logic        ovr;
        logic [31:0] add;
    } vec_t;

    vec_t tbl[$];

    pulse_rate_meter #(.WIDTH(32), .SYNC(0)) dut0 (
        .clk(clk), .rst(rst), .ena(ena), .pls(pls),
        .max(max), .add(add0), .vld(vld0), .rdy(rdy),
        .ovr(ovr0)
    );

    pulse_rate_meter #(.WIDTH(32), .SYNC(2)) dut2 (
        .clk(clk), .rst(rst), .ena(ena), .pls(pls),
        .max(max), .add(add2), .vld(vld2), .rdy(rdy),
        .ovr(ovr2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0 keeps pls, 1 pulses every 4th cycle, 2 is a 3/10 fractional stream
    task automatic gen(input int mode);
        if (mode == 1) begin
            pls = ((tgen % 4) == 0);
        end else if (mode == 2) begin
            facc = facc + 3;
            if (facc >= 10) begin
                facc = facc - 10;
                pls  = 1'b1;
            end else begin
                pls = 1'b0;
            end
        end
        tgen++;
    endtask

    task automatic tick_gen(input int mode);
        tick();
        gen(mode);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst  = 1'b0;
        tgen = 0;
        facc = 0;
    endtask

    task automatic wait_vld(input bit use2, input int mode,
                            input int bound, output int n);
        n = 0;
        do begin
            tick_gen(mode);
            n++;
        end while (!(use2 ? vld2 : vld0) && n <= bound);
    endtask

    function automatic vec_t mk(logic r, logic e, logic p, logic y,
                                logic [31:0] m, logic v, logic o,
                                logic [31:0] a);
        vec_t x;
        x.rst = r; x.ena = e; x.pls = p; x.rdy = y;
        x.max = m; x.vld = v; x.ovr = o; x.add = a;
        return x;
    endfunction

    initial begin
        int n;
        int cnt;
        logic ev;

        // gapless max=8 windows with constant pulses, rdy=1
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 25; k++) begin
            ev = (k >= 9) && (((k - 9) % 8) == 0);
            tbl.push_back(mk(0, 1, 1, 1, 8, ev, 0,
                             (k >= 9) ? 32'd8 : 32'd0));
        end
        // two unconsumed max=5 windows, then one accept cycle
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 12; k++) begin
            tbl.push_back(mk(0, (k <= 11), 1, (k == 12), 5,
                             (k >= 6 && k <= 11), (k == 11),
                             (k >= 6) ? 32'd5 : 32'd0));
        end

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            ena = tbl[i].ena;
            pls = tbl[i].pls;
            rdy = tbl[i].rdy;
            max = tbl[i].max;
            tick();
            chk($sformatf("tbl[%0d].vld", i), 32'(vld0), 32'(tbl[i].vld));
            chk($sformatf("tbl[%0d].ovr", i), 32'(ovr0), 32'(tbl[i].ovr));
            chk($sformatf("tbl[%0d].add", i), add0, tbl[i].add);
        end

        // SYNC=2, one pulse in four, max=100
        ena = 1'b0; rdy = 1'b1; max = 100;
        do_reset();
        gen(1);
        for (int k = 0; k < 8; k++) tick_gen(1);
        ena = 1'b1;
        wait_vld(1'b1, 1, 200, n);
        chk("sync2 first latency", n, 101);
        chk("sync2 add w0", add2, 25);
        for (int w = 1; w <= 2; w++) begin
            wait_vld(1'b1, 1, 200, n);
            chk($sformatf("sync2 gap w%0d", w), n, 100);
            chk($sformatf("sync2 add w%0d", w), add2, 25);
        end

        // fractional-counter stream, addend 3 over max 10
        ena = 1'b0; max = 10; rdy = 1'b1;
        do_reset();
        gen(2);
        ena = 1'b1;
        cnt = 0;
        for (int k = 0; k < 80; k++) begin
            tick_gen(2);
            if (vld0) begin
                cnt++;
                chk($sformatf("frac add r%0d", cnt), add0, 3);
            end
        end
        chk("frac result count", cnt, 7);

        // abort at cyc=3, then a full fresh window
        ena = 1'b0; pls = 1'b1; max = 10; rdy = 1'b1;
        do_reset();
        ena = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) tick();
        ena = 1'b0;
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (vld0) cnt++;
        end
        chk("abort no vld", cnt, 0);
        ena = 1'b1;
        wait_vld(1'b0, 0, 50, n);
        chk("abort restart latency", n, 11);
        chk("abort restart add", add0, 10);

        // asynchronous reset mid-window while a result is held
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("pre-reset vld", 32'(vld0), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst add", add0, 0);
        chk("async rst vld", 32'(vld0), 0);
        chk("async rst ovr", 32'(ovr0), 0);
        max = 4; rdy = 1'b1; ena = 1'b1; pls = 1'b1;
        #1;
        rst = 1'b0;
        wait_vld(1'b0, 0, 50, n);
        chk("post-rst latency", n, 5);
        chk("post-rst add", add0, 4);

        // max=0 never starts a window
        ena = 1'b0; max = 0;
        do_reset();
        ena = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (vld0 || vld2) cnt++;
        end
        chk("max0 no vld", cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
